fact_seq: RTL and testbench

Sequential factorial engine that computes n! for an unsigned operand using an iterative multiply loop. The loop-termination test is performed by the team's existing `cmp` greater-than comparator, which this block instantiates and whose `gt_` output it consumes every cycle. It sits between a simple start/operand source and any result consumer, and is the stage directly downstream of `cmp` in the factorial datapath.

---
 rtl/fact_seq_pkg.sv | 10 +
 rtl/fact_seq_cmp.sv | 10 +
 rtl/fact_seq.sv | 69 ++++++
 tb/tb_fact_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fact_seq_pkg.sv
// fact_pkg: shared state encoding and default widths for the factorial engine
package fact_pkg;
  localparam int DEF_SIZE = 8;
  localparam int DEF_RES_SIZE = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fact_seq_cmp.sv
// cmp: unsigned greater-than comparator
module cmp #(
  parameter int SIZE_ = 8
) (
  input  logic [SIZE_-1:0] a_,
  input  logic [SIZE_-1:0] b_,
  output logic             gt_
);
  assign gt_ = a_ > b_;
endmodule

// File: rtl/fact_seq.sv
// fact_seq: iterative n! engine with sticky overflow, loop exit decided by cmp
module fact_seq
  import fact_pkg::*;
#(
  parameter int SIZE_ = DEF_SIZE,
  parameter int RES_SIZE_ = DEF_RES_SIZE
) (
  input  logic                 clk_,
  input  logic                 rst_,
  input  logic                 start_,
  input  logic [SIZE_-1:0]     n_,
  output logic                 busy_,
  output logic                 done_,
  output logic [RES_SIZE_-1:0] result_,
  output logic                 ovf_
);
  state_t state, nxt;
  logic [SIZE_-1:0] n_r;
  logic [SIZE_:0] i_r;
  logic [RES_SIZE_-1:0] acc_r;
  logic ovf_r;
  logic gt;
  logic [RES_SIZE_+SIZE_:0] prod;
  // i_r is one bit wider than n so the counter reaches n+1 without wrapping
  cmp #(.SIZE_(SIZE_ + 1)) u_cmp (
    .a_ (i_r),
    .b_ ({1'b0, n_r}),
    .gt_(gt)
  );
  assign prod = {{(SIZE_ + 1){1'b0}}, acc_r} * {{RES_SIZE_{1'b0}}, i_r};
  // state register
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) state <= IDLE;
    else state <= nxt;
  end
  // next state: leave CALC once the counter passes n
  always_comb begin
    nxt = state == IDLE ? (start_ ? CALC : IDLE) :
          state == CALC ? (gt ? DONE : CALC) : IDLE;
  end
  // outputs decoded straight from the state flops
  always_comb begin
    busy_ = state != IDLE;
    done_ = state == DONE;
  end
  // datapath: load on accepted start, multiply per CALC cycle, publish on exit
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      n_r <= '0;
      i_r <= '0;
      acc_r <= '0;
      ovf_r <= 1'b0;
      result_ <= '0;
      ovf_ <= 1'b0;
    end else if (state == IDLE && start_) begin
      n_r <= n_;
      i_r <= (SIZE_ + 1)'(2);
      acc_r <= RES_SIZE_'(1);
      ovf_r <= 1'b0;
    end else if (state == CALC && gt) begin
      result_ <= acc_r;
      ovf_ <= ovf_r;
    end else if (state == CALC) begin
      acc_r <= prod[RES_SIZE_-1:0];
      ovf_r <= ovf_r | (|prod[RES_SIZE_+SIZE_:RES_SIZE_]);
      i_r <= i_r + 1'b1;
    end
  end
endmodule

// File: tb/tb_fact_seq.sv
// tb_fact_seq: table, corner-case and random checks of fact_seq against an arithmetic model
module tb_fact_seq;
  logic clk_ = 1'b0;
  logic rst_ = 1'b1;
  logic start_ = 1'b0;
  logic [7:0] n_ = '0;
  logic busy_, done_, ovf_;
  logic [31:0] result_;
  int n_vec = 0;
  int n_fail = 0;
  typedef struct {
    int n;
    logic [31:0] r;
    logic o;
  } vec_t;
  vec_t tbl[12];

  fact_seq dut (
    .clk_(clk_), .rst_(rst_), .start_(start_), .n_(n_),
    .busy_(busy_), .done_(done_), .result_(result_), .ovf_(ovf_)
  );

  always #5 clk_ = ~clk_;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // true factorial mod 2^32, overflow once any partial product needs more than 32 bits
  function automatic void model(input int n, output logic [31:0] r, output logic o);
    longint unsigned acc;
    acc = 1;
    o = 1'b0;
    for (int k = 2; k <= n; k++) begin
      acc = acc * longint'(k);
      if ((acc >> 32) != 0) o = 1'b1;
      acc = acc & 64'hFFFF_FFFF;
    end
    r = acc[31:0];
  endfunction

  // wait for done after t0 has already happened; checks latency, results and the single pulse
  task automatic finish_req(input int n, input logic [31:0] er, input logic eo, input string tag);
    int lat;
    lat = 0;
    while (!done_ && lat < 400) begin
      @(posedge clk_);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'((n < 2) ? 1 : n));
    chk({tag, " result"}, 64'(result_), 64'(er));
    chk({tag, " ovf"}, 64'(ovf_), 64'(eo));
    @(posedge clk_);
    #1;
    chk({tag, " done width"}, 64'(done_), 64'd0);
    chk({tag, " busy end"}, 64'(busy_), 64'd0);
  endtask

  task automatic run(input int n, input logic [31:0] er, input logic eo, input string tag);
    @(negedge clk_);
    start_ = 1'b1;
    n_ = 8'(n);
    @(posedge clk_);
    #1;
    start_ = 1'b0;
    chk({tag, " busy t0"}, 64'(busy_), 64'd1);
    finish_req(n, er, eo, tag);
  endtask

  initial begin
    logic [31:0] mr;
    logic mo;
    int n;
    int dones;
    tbl[0]  = '{0, 32'd1, 1'b0};
    tbl[1]  = '{1, 32'd1, 1'b0};
    tbl[2]  = '{2, 32'd2, 1'b0};
    tbl[3]  = '{3, 32'd6, 1'b0};
    tbl[4]  = '{5, 32'd120, 1'b0};
    tbl[5]  = '{7, 32'd5040, 1'b0};
    tbl[6]  = '{10, 32'd3628800, 1'b0};
    tbl[7]  = '{12, 32'd479001600, 1'b0};
    tbl[8]  = '{13, 32'd1932053504, 1'b1};
    tbl[9]  = '{33, 32'h8000_0000, 1'b1};
    tbl[10] = '{34, 32'd0, 1'b1};
    tbl[11] = '{255, 32'd0, 1'b1};
    #1;
    chk("reset busy", 64'(busy_), 64'd0);
    chk("reset done", 64'(done_), 64'd0);
    chk("reset result", 64'(result_), 64'd0);
    chk("reset ovf", 64'(ovf_), 64'd0);
    repeat (2) @(negedge clk_);
    rst_ = 1'b0;
    // start_ low in IDLE must not launch anything
    repeat (3) @(posedge clk_);
    #1;
    chk("idle busy", 64'(busy_), 64'd0);
    foreach (tbl[i]) run(tbl[i].n, tbl[i].r, tbl[i].o, $sformatf("tbl n=%0d", tbl[i].n));
    // async reset partway through n=10, at t4
    @(negedge clk_);
    start_ = 1'b1;
    n_ = 8'd10;
    @(posedge clk_);
    #1;
    start_ = 1'b0;
    repeat (4) @(posedge clk_);
    #2;
    rst_ = 1'b1;
    #1;
    chk("midrst busy", 64'(busy_), 64'd0);
    chk("midrst done", 64'(done_), 64'd0);
    chk("midrst result", 64'(result_), 64'd0);
    chk("midrst ovf", 64'(ovf_), 64'd0);
    @(negedge clk_);
    rst_ = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_);
      #1;
      if (done_ || busy_) dones++;
    end
    chk("midrst no resume", 64'(dones), 64'd0);
    run(3, 32'd6, 1'b0, "after rst n=3");
    // start_ held high through n=4 with n_ switched to 9 mid-run
    @(negedge clk_);
    start_ = 1'b1;
    n_ = 8'd4;
    @(posedge clk_);
    #1;
    @(posedge clk_);
    #1;
    n_ = 8'd9;
    dones = 0;
    while (!done_ && dones < 50) begin
      @(posedge clk_);
      #1;
      dones++;
    end
    chk("held n=4 result", 64'(result_), 64'd24);
    chk("held n=4 ovf", 64'(ovf_), 64'd0);
    @(posedge clk_);
    #1;
    chk("held gap idle", 64'(busy_), 64'd0);
    @(posedge clk_);
    #1;
    chk("held restart busy", 64'(busy_), 64'd1);
    start_ = 1'b0;
    finish_req(9, 32'd362880, 1'b0, "held n=9");
    // random operands against the model
    for (int k = 0; k < 24; k++) begin
      n = (k % 4 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      model(n, mr, mo);
      repeat ($urandom_range(0, 3)) @(posedge clk_);
      run(n, mr, mo, $sformatf("rnd n=%0d", n));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
